// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: multi-round reaction-timer session sequencer with best/miss/false-start tracking
module reaction_session_ctrl #(
   parameter int ROUNDS       = 5,
   parameter int FAULT_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        delay_done,
   input  logic [6:0]  lfsr_val,
   input  logic [15:0] bcd_count,
   output logic        lfsr_en,
   output logic [6:0]  delay_val,
   output logic        timer_en,
   output logic        timer_rst,
   output logic        bcd_en,
   output logic        bcd_rst,
   output logic        led,
   output logic [3:0]  round_idx,
   output logic [15:0] last_time,
   output logic [15:0] best_time,
   output logic [3:0]  miss_cnt,
   output logic [3:0]  fault_cnt,
   output logic        false_start,
   output logic        done,
   output logic [2:0]  state
);
   typedef enum logic [2:0] {IDLE, ARM, WAIT, GO, CAPTURE, FAULT, DONE} state_t;
   localparam int FW = $clog2(FAULT_CYCLES + 1);
   state_t cur, nxt;
   logic start_q, stop_q, start_rise, stop_rise;
   logic [FW-1:0] fcnt;
   logic fault_end, last_round, new_session, timeout;
   assign start_rise  = start & ~start_q;
   assign stop_rise   = stop & ~stop_q;
   assign fault_end   = fcnt == FW'(FAULT_CYCLES - 1);
   assign last_round  = round_idx == 4'(ROUNDS - 1);
   assign new_session = (cur == IDLE || cur == DONE) && start_rise;
   assign timeout     = bcd_count == 16'h9999;
   assign state       = cur;
   always_ff @(posedge clk or posedge rst)
      if (rst) cur <= IDLE;
      else cur <= nxt;
   always_comb begin
      nxt         = cur;
      lfsr_en     = 1'b0;
      timer_en    = 1'b0;
      timer_rst   = 1'b0;
      bcd_en      = 1'b0;
      bcd_rst     = 1'b0;
      led         = 1'b0;
      false_start = 1'b0;
      done        = 1'b0;
      case (cur)
         IDLE: begin
            {lfsr_en, timer_rst, bcd_rst} = 3'b111;
            nxt = start_rise ? ARM : IDLE;
         end
         ARM: begin
            {lfsr_en, timer_rst, bcd_rst} = 3'b111;
            nxt = WAIT;
         end
         WAIT: begin
            timer_en = 1'b1;
            nxt = stop_rise ? FAULT : delay_done ? GO : WAIT;
         end
         GO: begin
            {led, bcd_en} = 2'b11;
            nxt = (stop_rise || timeout) ? CAPTURE : GO;
         end
         CAPTURE: nxt = last_round ? DONE : ARM;
         FAULT: begin
            {false_start, timer_rst, bcd_rst} = 3'b111;
            nxt = fault_end ? ARM : FAULT;
         end
         DONE: begin
            done = 1'b1;
            nxt = start_rise ? ARM : DONE;
         end
         default: nxt = IDLE;
      endcase
   end
   // Edge-detect flops reset high so a button held through reset is not an edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         start_q   <= 1'b1;
         stop_q    <= 1'b1;
         fcnt      <= '0;
         delay_val <= 7'd1;
         round_idx <= '0;
         last_time <= '0;
         best_time <= 16'h9999;
         miss_cnt  <= '0;
         fault_cnt <= '0;
      end else begin
         start_q <= start;
         stop_q  <= stop;
         fcnt    <= (cur == FAULT) ? fcnt + 1'b1 : '0;
         if (new_session) begin
            round_idx <= '0;
            last_time <= '0;
            best_time <= 16'h9999;
            miss_cnt  <= '0;
            fault_cnt <= '0;
         end
         if (cur == ARM) delay_val <= (lfsr_val == 7'd0) ? 7'd1 : lfsr_val;
         if (cur == WAIT && stop_rise && fault_cnt != 4'hf) fault_cnt <= fault_cnt + 1'b1;
         if (cur == GO && !stop_rise && timeout && miss_cnt != 4'hf) miss_cnt <= miss_cnt + 1'b1;
         // A timed-out capture reads 9999, which can never beat best_time
         if (cur == CAPTURE) begin
            last_time <= bcd_count;
            if (bcd_count < best_time) best_time <= bcd_count;
            if (!last_round) round_idx <= round_idx + 1'b1;
         end
      end
endmodule

// File: tb/tb_reaction_session_ctrl.sv
// tb_reaction_session_ctrl: table-driven directed check of the session controller (ROUNDS=2, FAULT_CYCLES=4)
module tb_reaction_session_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic start = 1'b1, stop = 1'b1, delay_done = 1'b0;
   logic [6:0] lfsr_val = '0;
   logic [15:0] bcd_count = '0;
   logic lfsr_en, timer_en, timer_rst, bcd_en, bcd_rst, led, false_start, done;
   logic [6:0] delay_val;
   logic [3:0] round_idx, miss_cnt, fault_cnt;
   logic [15:0] last_time, best_time;
   logic [2:0] state;
   int checks = 0, errors = 0;
   typedef struct {
      logic st, sp, dd;
      logic [6:0] lf;
      logic [15:0] bcd;
      logic [2:0] es;
      logic [3:0] er;
      logic [6:0] ed;
      logic [15:0] el, eb;
      logic [3:0] em, ef;
   } vec_t;
   vec_t tv[$];
   reaction_session_ctrl #(.ROUNDS(2), .FAULT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .delay_done(delay_done),
      .lfsr_val(lfsr_val), .bcd_count(bcd_count), .lfsr_en(lfsr_en), .delay_val(delay_val),
      .timer_en(timer_en), .timer_rst(timer_rst), .bcd_en(bcd_en), .bcd_rst(bcd_rst),
      .led(led), .round_idx(round_idx), .last_time(last_time), .best_time(best_time),
      .miss_cnt(miss_cnt), .fault_cnt(fault_cnt), .false_start(false_start), .done(done),
      .state(state)
   );
   always #5 clk = ~clk;
   function automatic logic [7:0] exp_outs(input logic [2:0] s);
      case (s)
         3'd0, 3'd1: return 8'b1010_1000;
         3'd2: return 8'b0100_0000;
         3'd3: return 8'b0001_0100;
         3'd5: return 8'b0010_1010;
         3'd6: return 8'b0000_0001;
         default: return 8'b0000_0000;
      endcase
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic chk_state(input string tag, input logic [2:0] es);
      chk({tag, " state"}, 32'(state), 32'(es));
      chk({tag, " outs"}, 32'({lfsr_en, timer_en, timer_rst, bcd_en, bcd_rst, led, false_start, done}), 32'(exp_outs(es)));
   endtask
   task automatic apply(input logic st, input logic sp, input logic dd, input logic [6:0] lf, input logic [15:0] bcd);
      @(negedge clk);
      start = st; stop = sp; delay_done = dd; lfsr_val = lf; bcd_count = bcd;
      @(posedge clk);
      #1;
   endtask
   task automatic add(input logic st, sp, dd, input logic [6:0] lf, input logic [15:0] bcd, input logic [2:0] es,
                      input logic [3:0] er, input logic [6:0] ed, input logic [15:0] el, eb, input logic [3:0] em, ef);
      vec_t v;
      v.st = st; v.sp = sp; v.dd = dd; v.lf = lf; v.bcd = bcd; v.es = es;
      v.er = er; v.ed = ed; v.el = el; v.eb = eb; v.em = em; v.ef = ef;
      tv.push_back(v);
   endtask
   initial begin
      // start/stop held through reset: no edge afterwards
      add(1,1,0,0,0,       0,0,1,16'h0000,16'h9999,0,0);
      add(0,0,0,0,0,       0,0,1,16'h0000,16'h9999,0,0);
      add(1,0,0,0,0,       1,0,1,16'h0000,16'h9999,0,0);
      add(0,0,0,5,0,       2,0,5,16'h0000,16'h9999,0,0);
      add(0,0,0,0,0,       2,0,5,16'h0000,16'h9999,0,0);
      add(0,0,1,0,0,       3,0,5,16'h0000,16'h9999,0,0);
      add(1,0,0,0,16'h0100,3,0,5,16'h0000,16'h9999,0,0);
      add(0,1,0,0,16'h0120,4,0,5,16'h0000,16'h9999,0,0);
      add(0,0,0,0,16'h0120,1,1,5,16'h0120,16'h0120,0,0);
      add(0,0,0,0,0,       2,1,1,16'h0120,16'h0120,0,0);
      add(0,1,0,0,0,       5,1,1,16'h0120,16'h0120,0,1);
      add(0,0,0,0,0,       5,1,1,16'h0120,16'h0120,0,1);
      add(0,1,0,0,0,       5,1,1,16'h0120,16'h0120,0,1);
      add(0,0,0,0,0,       5,1,1,16'h0120,16'h0120,0,1);
      add(0,0,0,0,0,       1,1,1,16'h0120,16'h0120,0,1);
      add(0,0,0,9,0,       2,1,9,16'h0120,16'h0120,0,1);
      // stop rise together with delay_done: stop wins
      add(0,1,1,0,0,       5,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,0,0,       5,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,0,0,       5,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,0,0,       5,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,0,0,       1,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,9,0,       2,1,9,16'h0120,16'h0120,0,2);
      add(0,0,1,0,0,       3,1,9,16'h0120,16'h0120,0,2);
      add(0,0,0,0,16'h9999,4,1,9,16'h0120,16'h0120,1,2);
      add(0,0,0,0,16'h9999,6,1,9,16'h9999,16'h0120,1,2);
      add(0,1,0,0,0,       6,1,9,16'h9999,16'h0120,1,2);
      add(1,0,0,0,0,       1,0,9,16'h0000,16'h9999,0,0);
      add(0,0,0,3,0,       2,0,3,16'h0000,16'h9999,0,0);
      add(0,0,1,0,0,       3,0,3,16'h0000,16'h9999,0,0);
      add(0,1,0,0,16'h0120,4,0,3,16'h0000,16'h9999,0,0);
      add(0,0,0,0,16'h0120,1,1,3,16'h0120,16'h0120,0,0);
      add(0,0,0,7,0,       2,1,7,16'h0120,16'h0120,0,0);
      add(0,0,1,0,0,       3,1,7,16'h0120,16'h0120,0,0);
      add(0,1,0,0,16'h0080,4,1,7,16'h0120,16'h0120,0,0);
      add(0,0,0,0,16'h0080,6,1,7,16'h0080,16'h0080,0,0);
      add(0,0,0,0,0,       6,1,7,16'h0080,16'h0080,0,0);
      repeat (3) @(posedge clk);
      #1;
      chk_state("in_reset", 3'd0);
      chk("in_reset best", 32'(best_time), 32'h9999);
      chk("in_reset delay", 32'(delay_val), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < tv.size(); i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         apply(tv[i].st, tv[i].sp, tv[i].dd, tv[i].lf, tv[i].bcd);
         chk_state(tag, tv[i].es);
         chk({tag, " round"}, 32'(round_idx), 32'(tv[i].er));
         chk({tag, " delay"}, 32'(delay_val), 32'(tv[i].ed));
         chk({tag, " last"}, 32'(last_time), 32'(tv[i].el));
         chk({tag, " best"}, 32'(best_time), 32'(tv[i].eb));
         chk({tag, " miss"}, 32'(miss_cnt), 32'(tv[i].em));
         chk({tag, " fault"}, 32'(fault_cnt), 32'(tv[i].ef));
      end
      // stop rise and 9999 in the same GO cycle is a normal press, not a miss
      apply(1,0,0,0,0);
      chk_state("rs_arm", 3'd1);
      apply(0,0,0,0,0);
      chk("rs_delay0", 32'(delay_val), 32'd1);
      apply(0,0,1,0,0);
      chk_state("rs_go", 3'd3);
      apply(0,1,0,0,16'h9999);
      chk_state("rs_cap", 3'd4);
      chk("rs_miss", 32'(miss_cnt), 32'd0);
      apply(0,0,0,0,16'h9999);
      chk_state("rs_arm2", 3'd1);
      chk("rs_last", 32'(last_time), 32'h9999);
      chk("rs_best", 32'(best_time), 32'h9999);
      chk("rs_round", 32'(round_idx), 32'd1);
      apply(0,0,0,4,0);
      apply(0,0,1,0,0);
      chk_state("ar_go", 3'd3);
      // asynchronous reset in the middle of GO takes effect without a clock edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_state("ar_now", 3'd0);
      chk("ar_led", 32'(led), 32'd0);
      chk("ar_round", 32'(round_idx), 32'd0);
      chk("ar_delay", 32'(delay_val), 32'd1);
      #2;
      rst = 1'b0;
      apply(0,0,0,0,0);
      chk_state("ar_idle", 3'd0);
      apply(1,0,0,0,0);
      chk_state("ar_restart", 3'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reaction_session_ctrl.md
# reaction_session_ctrl

Multi-round session controller for the reaction-timer datapath. It sequences the LFSR, delay up-timer and 4-digit BCD reaction counter through a fixed number of rounds. Per round it latches a random delay, drives the "go" LED, captures the BCD reaction time, and rejects false starts. It also tracks the session best time, timeouts and false-start count. It runs on the 1 kHz system tick and replaces single-shot sequencing in the top level when session mode is selected.

## Interface
- ROUNDS, 5, rounds per session; legal range 1..15
- FAULT_CYCLES, 1000, cycles the false-start indication is held before re-arming; must be ≥1
- clk  in  1  1 kHz system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  start button, active-high level, synchronous to clk
- stop  in  1  reaction button, active-high level, synchronous to clk
- delay_done  in  1  trigger from delay up-timer
- lfsr_val  in  7  current LFSR output
- bcd_count  in  16  4-digit BCD reaction count
- lfsr_en  out  1  LFSR enable
- delay_val  out  7  latched delay target to up-timer
- timer_en / timer_rst  out  1 each  up-timer enable / synchronous clear
- bcd_en / bcd_rst  out  1 each  BCD counter enable / synchronous clear
- led  out  1  "go" indicator
- round_idx  out  4  current round, 0-based
- last_time  out  16  BCD time of most recent captured round
- best_time  out  16  minimum captured BCD time this session
- miss_cnt  out  4  timeouts this session, saturating at 15
- fault_cnt  out  4  false starts this session, saturating at 15
- false_start  out  1  high while in FAULT
- done  out  1  high while in DONE
- state  out  3  state code, for the HEX state display

## Operation
- Edge detect on start and stop: `rise = x & ~x_q`. Both `x_q` registers reset to 1, so a button held through reset produces no edge.
- State codes: IDLE=0, ARM=1, WAIT=2, GO=3, CAPTURE=4, FAULT=5, DONE=6; code 7 goes to IDLE.
- IDLE: lfsr_en=1, timer_rst=1, bcd_rst=1.
  - On start rise, clear session registers (round_idx=0, best_time=16'h9999, last_time=0, miss_cnt=0, fault_cnt=0) and go to ARM.
- ARM (1 cycle): delay_val <= (lfsr_val==0) ? 1 : lfsr_val. timer_rst=1, bcd_rst=1, lfsr_en=1. Go to WAIT.
- WAIT: timer_en=1.
  - stop rise → FAULT; fault_cnt++ (saturating).
  - Otherwise delay_done → GO.
  - Simultaneous stop rise and delay_done → FAULT (stop wins).
- GO: led=1, bcd_en=1.
  - stop rise → CAPTURE.
  - bcd_count==16'h9999 without stop rise → CAPTURE as a timeout; miss_cnt++ (saturating).
  - Both in the same cycle → normal press, not a miss.
- CAPTURE (1 cycle): last_time <= bcd_count.
  - If bcd_count < best_time (unsigned compare, valid for BCD), best_time <= bcd_count. Timeouts still update last_time but never best_time.
  - If round_idx==ROUNDS-1 → DONE; else round_idx++ and go to ARM.
- FAULT: false_start=1, timer_rst=1, bcd_rst=1. An internal counter runs FAULT_CYCLES cycles, then goes to ARM with the same round_idx (the round is repeated). Stop edges are ignored in FAULT.
- DONE: done=1, and all results are held.
  - On start rise, clear the session as from IDLE and go to ARM.
- start rise is ignored in ARM, WAIT, GO, CAPTURE and FAULT.
- Outputs not listed for a state are 0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Reset values:
  - state=IDLE; all enables 0 except lfsr_en=1, timer_rst=1, bcd_rst=1.
  - delay_val=1, round_idx=0, last_time=0, best_time=16'h9999, miss_cnt=0, fault_cnt=0, led=0, false_start=0, done=0.
- Reset mid-round returns to IDLE immediately (async). The next active edge behaves as IDLE.
- Input edge at cycle n → state change visible after clock edge n+1 (one-cycle detection, registered transition).
- led rises on the first cycle in GO: one cycle after delay_done is sampled.
- The BCD counter counts during GO only. Reported time = GO cycles before stop rise, in ms at 1 kHz.
- ARM and CAPTURE last exactly 1 cycle. FAULT lasts exactly FAULT_CYCLES cycles.

## Test plan
- Reset with start and stop held high: no transition. State stays 0, best_time=9999.
- ROUNDS=2, FAULT_CYCLES=4. Start pulse, lfsr_val=5, stop 120 cycles after led rises, round 2 stop at 80 → last_time=0080, best_time=0080, round_idx=1, done=1, state=6.
- Stop pulse during WAIT → false_start high exactly 4 cycles, fault_cnt=1, round_idx unchanged, returns to ARM→WAIT.
- Stop rise and delay_done in the same cycle → FAULT, not GO; led never asserts.
- No stop in GO, bcd_count driven to 9999 → miss_cnt=1, last_time=9999, best_time unchanged.
- lfsr_val=0 at ARM → delay_val=1. Async rst asserted mid-GO → led=0 and state=0 immediately. Start pulse in DONE → counters cleared, state=1.
